// File: rtl/dram_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_burst_responder
// Description : Behavioural DRAM stand-in for an instruction cache. Accepts a
//               level block-fill request, waits LATENCY cycles, then streams
//               an 8-word aligned block from a backdoor-loadable store.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_burst_responder #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DRAM_req,
    input  logic [31:0]       DRAM_req_PC,
    output logic [31:0]       DRAM_data,
    output logic              DRAM_valid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam int unsigned c_BURST_LEN  = 8;
    localparam logic [2:0]  c_LAST_BEAT  = 3'(c_BURST_LEN - 1);
    localparam logic [7:0]  c_LAT_LOAD   = 8'(LATENCY - 1);

    // Backing store; deliberately has no reset so preloaded code survives it.
    logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_lat_cnt;
    logic [7:0]        w_lat_nxt;
    logic [2:0]        r_beat;
    logic [2:0]        w_beat_nxt;
    logic [2:0]        w_beat_inc;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_fire;
    logic [31:0]       r_data;
    logic              r_valid;
    logic              w_unused_pc;

    // Low three PC bits and bits above ADDR_W are intentionally discarded.
    assign w_unused_pc = ^DRAM_req_PC;

    // The base is 8-aligned, so base+beat is just the beat in the low bits.
    assign w_beat_inc = r_beat + 3'd1;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE waits for the cache to drop its request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (DRAM_req)              w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (r_lat_cnt == 8'd0)     w_state_nxt = c_ST_BURST;
            c_ST_BURST: if (r_beat == c_LAST_BEAT) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (!DRAM_req)             w_state_nxt = c_ST_IDLE;
            default:                               w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output/datapath decode: capture, latency countdown and beat selection.
    always_comb begin
        w_fire     = 1'b0;
        w_rd_addr  = r_base;
        w_lat_nxt  = r_lat_cnt;
        w_beat_nxt = r_beat;
        w_base_nxt = r_base;
        busy       = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                if (DRAM_req) begin
                    w_base_nxt = {DRAM_req_PC[ADDR_W-1:3], 3'b000};
                    w_lat_nxt  = c_LAT_LOAD;
                end
            end
            c_ST_WAIT: begin
                if (r_lat_cnt == 8'd0) begin
                    w_fire     = 1'b1;
                    w_rd_addr  = r_base;
                    w_beat_nxt = 3'd0;
                end else begin
                    w_lat_nxt = r_lat_cnt - 8'd1;
                end
            end
            c_ST_BURST: begin
                if (r_beat != c_LAST_BEAT) begin
                    w_fire     = 1'b1;
                    w_rd_addr  = {r_base[ADDR_W-1:3], w_beat_inc};
                    w_beat_nxt = w_beat_inc;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; the read sees pre-write memory contents.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lat_cnt <= 8'd0;
            r_beat    <= 3'd0;
            r_base    <= '0;
            r_valid   <= 1'b0;
            r_data    <= 32'h0;
        end else begin
            r_lat_cnt <= w_lat_nxt;
            r_beat    <= w_beat_nxt;
            r_base    <= w_base_nxt;
            r_valid   <= w_fire;
            r_data    <= w_fire ? r_mem[w_rd_addr] : 32'h0;
        end
    end

    // Backdoor write port, active regardless of state or reset.
    always_ff @(posedge CLK) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign DRAM_data  = r_data;
    assign DRAM_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_burst_responder
// Description : Self-checking bench for dram_burst_responder. Two instances
//               (LATENCY=10 and LATENCY=1) share stimulus; a timestamp-based
//               transaction model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_burst_responder;

    localparam int L0 = 10;
    localparam int L1 = 1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        DRAM_req;
    logic [31:0] DRAM_req_PC;
    logic        load_en;
    logic [11:0] load_addr;
    logic [31:0] load_data;
    logic [31:0] data0, data1;
    logic        valid0, valid1, busy0, busy1;

    always #5 CLK = ~CLK;

    dram_burst_responder #(.LATENCY(L0), .ADDR_W(12)) dut (
        .CLK(CLK), .RESET(RESET), .DRAM_req(DRAM_req), .DRAM_req_PC(DRAM_req_PC),
        .DRAM_data(data0), .DRAM_valid(valid0), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy0));

    dram_burst_responder #(.LATENCY(L1), .ADDR_W(12)) dut_l1 (
        .CLK(CLK), .RESET(RESET), .DRAM_req(DRAM_req), .DRAM_req_PC(DRAM_req_PC),
        .DRAM_data(data1), .DRAM_valid(valid1), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy1));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction model: a request captured at cycle t0 yields beats at
    // cycles t0+L .. t0+L+7; the responder frees up at the first cycle
    // >= t0+L+9 where the request is sampled low.
    bit          m_act  [2];
    int          m_t0   [2];
    int          m_base [2];
    logic        m_v    [2];
    logic [31:0] m_d    [2];
    logic        m_b    [2];
    logic [31:0] shadow [4096];

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_b;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, {31'd0, got}, {31'd0, exp});
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int lat;
            int k;
            lat = (d == 0) ? L0 : L1;
            if (RESET) begin
                m_act[d] = 1'b0;
                m_v[d]   = 1'b0;
                m_d[d]   = 32'h0;
            end else if (!m_act[d]) begin
                m_v[d] = 1'b0;
                m_d[d] = 32'h0;
                if (DRAM_req) begin
                    m_act[d]  = 1'b1;
                    m_t0[d]   = cyc;
                    m_base[d] = int'(DRAM_req_PC[11:0] & 12'hFF8);
                end
            end else begin
                k = cyc - m_t0[d];
                if (k >= lat && k < lat + 8) begin
                    m_v[d] = 1'b1;
                    m_d[d] = shadow[12'(m_base[d] + k - lat)];
                end else begin
                    m_v[d] = 1'b0;
                    m_d[d] = 32'h0;
                    if (k >= lat + 9 && !DRAM_req) m_act[d] = 1'b0;
                end
            end
            m_b[d] = m_act[d];
        end
        if (load_en) shadow[load_addr] = load_data;
    endtask

    // One clock: sample 1 time unit after the edge, advance the model, compare.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        model_step();
        chk1("sb_valid0", valid0, m_v[0]);
        chk ("sb_data0",  data0,  m_d[0]);
        chk1("sb_busy0",  busy0,  m_b[0]);
        chk1("sb_valid1", valid1, m_v[1]);
        chk ("sb_data1",  data1,  m_d[1]);
        chk1("sb_busy1",  busy1,  m_b[1]);
    endtask

    function automatic void add(input logic req, input logic [31:0] pc, input logic v,
                                input logic [31:0] d, input logic b);
        vec_t x;
        x.req = req; x.pc = pc; x.exp_v = v; x.exp_d = d; x.exp_b = b;
        vecs.push_back(x);
    endfunction

    // Single-cycle request pulse, then explicit beat checks on both instances.
    task automatic burst(input logic [31:0] pc, input logic [31:0] first,
                         input int coll, input int patch_idx, input logic [31:0] patch_val);
        logic [11:0] blk;
        int          b;
        logic [31:0] e;
        blk = pc[11:0] & 12'hFF8;
        DRAM_req    = 1'b1;
        DRAM_req_PC = pc;
        tick();
        DRAM_req    = 1'b0;
        DRAM_req_PC = ~pc;
        for (int k = 1; k <= L0 + 9; k++) begin
            if (coll >= 0 && k == L0 + coll) begin
                load_en   = 1'b1;
                load_addr = blk + 12'(coll);
                load_data = 32'h0000_DEAD;
            end
            tick();
            load_en = 1'b0;
            b = k - L0;
            e = (b == patch_idx) ? patch_val : first + 32'(b);
            chk1($sformatf("burst0_k%0d_valid", k), valid0, (b >= 0 && b < 8));
            chk ($sformatf("burst0_k%0d_data", k), data0, (b >= 0 && b < 8) ? e : 32'h0);
            chk1($sformatf("burst0_k%0d_busy", k), busy0, (k <= L0 + 8));
            b = k - L1;
            e = (b == patch_idx) ? patch_val : first + 32'(b);
            chk1($sformatf("burst1_k%0d_valid", k), valid1, (b >= 0 && b < 8));
            chk ($sformatf("burst1_k%0d_data", k), data1, (b >= 0 && b < 8) ? e : 32'h0);
            chk1($sformatf("burst1_k%0d_busy", k), busy1, (k <= L1 + 8));
        end
    endtask

    initial begin
        int beats;
        RESET       = 1'b1;
        DRAM_req    = 1'b0;
        DRAM_req_PC = 32'h0;
        load_en     = 1'b0;
        load_addr   = 12'h0;
        load_data   = 32'h0;

        // Reset state.
        tick();
        chk1("rst_valid0", valid0, 1'b0);
        chk ("rst_data0",  data0,  32'h0);
        chk1("rst_busy0",  busy0,  1'b0);
        chk1("rst_busy1",  busy1,  1'b0);

        // Preload the whole store while reset is held.
        for (int i = 0; i < 4096; i++) begin
            load_en   = 1'b1;
            load_addr = 12'(i);
            load_data = $urandom;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            load_addr = 12'h100 + 12'(i); load_data = 32'hA0 + 32'(i);        tick();
            load_addr = 12'h200 + 12'(i); load_data = 32'h5500 + 32'(i);      tick();
            load_addr = 12'hFF8 + 12'(i); load_data = 32'hC000_0000 + 32'(i); tick();
        end
        load_en = 1'b0;
        RESET   = 1'b0;
        tick();

        // Table: one-cycle pulse (PC changes after capture), then held request.
        add(1'b1, 32'h103, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 9; i++) add(1'b0, 32'hABC, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++)  add(1'b0, 32'hABC, 1'b1, 32'hA0 + 32'(i), 1'b1);
        add(1'b0, 32'hABC, 1'b0, 32'h0, 1'b1);
        add(1'b0, 32'hABC, 1'b0, 32'h0, 1'b0);
        add(1'b0, 32'hABC, 1'b0, 32'h0, 1'b0);
        add(1'b1, 32'h107, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 9; i++) add(1'b1, 32'h107, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++)  add(1'b1, 32'h107, 1'b1, 32'hA0 + 32'(i), 1'b1);
        add(1'b1, 32'h107, 1'b0, 32'h0, 1'b1);
        add(1'b1, 32'h107, 1'b0, 32'h0, 1'b1);
        add(1'b0, 32'h107, 1'b0, 32'h0, 1'b0);
        add(1'b0, 32'h107, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            DRAM_req    = vecs[i].req;
            DRAM_req_PC = vecs[i].pc;
            tick();
            chk1($sformatf("vec%0d_valid", i), valid0, vecs[i].exp_v);
            chk ($sformatf("vec%0d_data", i),  data0,  vecs[i].exp_d);
            chk1($sformatf("vec%0d_busy", i),  busy0,  vecs[i].exp_b);
        end
        DRAM_req = 1'b0;
        tick();

        // Address wrap: upper PC bits ignored.
        burst(32'h0001_0FF8, 32'hC000_0000, -1, -1, 32'h0);
        // Collision on beat 5 returns old data; the next burst sees the new word.
        burst(32'h0000_0205, 32'h5500, 5, -1, 32'h0);
        burst(32'h0000_0200, 32'h5500, -1, 5, 32'h0000_DEAD);

        // Reset during beat 3 aborts the burst.
        DRAM_req    = 1'b1;
        DRAM_req_PC = 32'h100;
        tick();
        DRAM_req = 1'b0;
        beats    = 0;
        for (int k = 1; k <= L0 + 3; k++) begin
            tick();
            if (valid0 === 1'b1) beats++;
        end
        RESET = 1'b1;
        tick();
        chk1("abort_valid0", valid0, 1'b0);
        chk ("abort_data0",  data0,  32'h0);
        chk1("abort_busy0",  busy0,  1'b0);
        RESET = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid0 === 1'b1) beats++;
        end
        chk("abort_beat_count", 32'(beats), 32'd4);
        chk1("abort_idle_busy0", busy0, 1'b0);

        // Request held through reset is taken as a fresh request.
        DRAM_req = 1'b1;
        RESET    = 1'b1;
        tick();
        chk1("rstreq_busy0_in_reset", busy0, 1'b0);
        RESET = 1'b0;
        tick();
        chk1("rstreq_busy0_after", busy0, 1'b1);
        chk1("rstreq_busy1_after", busy1, 1'b1);
        DRAM_req = 1'b0;
        for (int k = 0; k < 25; k++) tick();
        chk1("rstreq_final_busy0", busy0, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) DRAM_req = ~DRAM_req;
            DRAM_req_PC = $urandom;
            load_en     = ($urandom_range(0, 3) == 0);
            load_addr   = ($urandom_range(0, 1) == 0) ? 12'(m_base[0] + int'($urandom_range(0, 7)))
                                                      : 12'($urandom);
            load_data   = $urandom;
            RESET       = ($urandom_range(0, 199) == 0);
            tick();
        end
        RESET   = 1'b0;
        load_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_burst_responder.md
DRAM_BURST_RESPONDER -- requirements
Module: dram_burst_responder

Interface
REQ-001 Parameter LATENCY, default 10: cycles from request capture to first data beat; legal range 1..255.
REQ-002 Parameter ADDR_W, default 12: log2 of backing store depth in 32-bit words.
REQ-003 Parameter BURST_LEN, fixed at 8: beats per block; not overridable.
REQ-004 CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 DRAM_req  input  1  level block-fill request from instruction cache.
REQ-007 DRAM_req_PC  input  32  word address of block; bits [2:0] are zero when issued by the cache.
REQ-008 DRAM_data  output  32  registered data beat.
REQ-009 DRAM_valid  output  1  registered; high for exactly one cycle per beat.
REQ-010 load_en  input  1  backdoor write strobe for preloading the store.
REQ-011 load_addr  input  ADDR_W  backdoor word address.
REQ-012 load_data  input  32  backdoor write data.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Backing store: 2^ADDR_W x 32-bit words, not cleared by RESET.
REQ-015 FSM states: IDLE, WAIT, BURST, DONE.
REQ-016 IDLE: when DRAM_req=1 at a clock edge, capture base = {DRAM_req_PC[ADDR_W-1:3], 3'b000}, load lat_cnt=LATENCY-1, and go to WAIT.
REQ-017 Base alignment: bits [2:0] of DRAM_req_PC are forced to 0; higher bits beyond ADDR_W are ignored, so the address wraps modulo 2^ADDR_W.
REQ-018 WAIT: decrement lat_cnt each cycle; on the edge where lat_cnt=0, go to BURST and register beat 0.
REQ-019 Timing: DRAM_req is sampled high at edge t; DRAM_valid first reads high after edge t+LATENCY.
REQ-020 BURST: beat i (i=0..7) drives DRAM_data=mem[base+i] with DRAM_valid=1, on 8 consecutive cycles with no gaps, word 0 first.
REQ-021 After beat 7 is registered, the next edge goes to DONE with DRAM_valid=0.
REQ-022 Beat counter: 3-bit, reset to 0 on entry to BURST. The address is base+beat, computed in ADDR_W bits. Base is 8-aligned, so a burst never crosses a block.
REQ-023 DONE: hold until DRAM_req is sampled 0, then go to IDLE; no new request is accepted in DONE. This absorbs the cache's one-to-two-cycle request deassert lag.
REQ-024 DRAM_req falling during WAIT or BURST is ignored; the burst always completes, and DONE then exits on the next edge.
REQ-025 DRAM_req_PC changes after capture have no effect on the current burst.
REQ-026 Outside BURST beats: DRAM_valid=0 and DRAM_data=32'h0.
REQ-027 Backdoor write: when load_en=1, mem[load_addr]<=load_data at the edge. This is accepted in any state, including during RESET.
REQ-028 Read/write collision: a beat read in the same cycle as a load to the same word returns the old data (read-before-write).
REQ-029 Only one outstanding request; no queuing.

Reset
REQ-030 RESET=1 at an edge forces: state=IDLE, DRAM_valid=0, DRAM_data=0, busy=0, lat_cnt=0, beat=0, base=0.
REQ-031 Reset mid-WAIT or mid-BURST aborts the burst immediately; no further beats are issued.
REQ-032 After reset deasserts, a still-high DRAM_req is treated as a new request from IDLE.
REQ-033 Memory contents survive reset.

Verification
REQ-034 Preload mem[0x100..0x107]=0xA0..0xA7; pulse DRAM_req high with DRAM_req_PC=0x103 at edge 5 (LATENCY=10) -> DRAM_valid high at edges 15..22 with data 0xA0..0xA7, then DRAM_valid=0.
REQ-035 Hold DRAM_req high for 2 cycles after the last beat, then drop it -> busy stays 1 through DONE, no second burst starts, and busy=0 the cycle after DRAM_req is sampled 0.
REQ-036 DRAM_req_PC=0x0001_0FF8, ADDR_W=12 -> beats come from mem[0xFF8..0xFFF], with no carry into upper bits.
REQ-037 Assert RESET for 1 cycle during beat 3 -> DRAM_valid=0 from the next edge; only 4 beats are observed; busy=0.
REQ-038 load_en writes 0xDEAD to base+5 in the same cycle beat 5 is registered -> beat 5 returns the old value; a second burst to the same block returns 0xDEAD.
REQ-039 LATENCY=1: DRAM_req sampled at edge t -> DRAM_valid high at edges t+1..t+8.
